// File: rtl/tetris_move_scheduler_pkg.sv
// tetris_pkg: shared types and constants for the tetris move scheduler
package tetris_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OVER} sched_state_t;
  typedef enum logic [1:0] {NONE, LEFT, RIGHT} joy_dir_t;
  typedef enum logic [1:0] {CMD_ROT, CMD_H, CMD_DN, CMD_G} cmd_t;
  localparam int LINES_PER_LEVEL = 10;
  localparam int LEVEL_MAX = 15;
endpackage

// File: rtl/tetris_move_scheduler_if.sv
// tetris_move_scheduler_if: command/status link between the scheduler and tetris_grid
interface tetris_move_scheduler_if;
  logic grid_ready;
  logic row_cleared;
  logic game_over;
  logic move_left;
  logic move_right;
  logic move_down;
  logic rotate;
  logic busy;
  logic [3:0] level;
  modport master (
    input grid_ready, row_cleared, game_over,
    output move_left, move_right, move_down, rotate, busy, level
  );
  modport slave (
    output grid_ready, row_cleared, game_over,
    input move_left, move_right, move_down, rotate, busy, level
  );
endinterface

// File: rtl/tetris_move_scheduler_btn_debounce.sv
// btn_debounce: synchronises a raw pushbutton, filters bounce and flags the debounced press
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int W = $clog2(DEBOUNCE_CYC + 1);
  logic raw_s, raw_p;
  logic [W-1:0] cnt;
  // any raw change restarts the count; level follows after DEBOUNCE_CYC stable cycles
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      raw_s <= 1'b0;
      raw_p <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      raw_s <= raw;
      raw_p <= raw_s;
      rise  <= 1'b0;
      if (raw_s != raw_p || raw_p == level) cnt <= '0;
      else if (cnt == W'(DEBOUNCE_CYC - 1)) begin
        cnt   <= '0;
        level <= raw_p;
        rise  <= raw_p;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/tetris_move_scheduler.sv
// tetris_move_scheduler: arbitrates gravity, joystick, rotate and soft drop into single move pulses
// LEVEL_SPEEDUP_EN: when defined, the gravity period shortens with the level
module tetris_move_scheduler
  import tetris_pkg::*;
#(
  parameter int GRAVITY_CYC  = 25000000,
  parameter int DAS_CYC      = 8000000,
  parameter int ARR_CYC      = 2500000,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int TH_RIGHT     = 2000,
  parameter int TH_LEFT      = 1300,
  parameter int HYST         = 50
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] adc_value,
  input  logic        btn_rotate,
  input  logic        btn_down,
  tetris_move_scheduler_if.master grid
);
  localparam int GW = $clog2(GRAVITY_CYC + 1);
  localparam int HW = $clog2((DAS_CYC > ARR_CYC ? DAS_CYC : ARR_CYC) + 1);
  sched_state_t state, state_nx;
  joy_dir_t dir, dir_hold, dir_nx;
  cmd_t win;
  logic pend_rot, pend_h, pend_dn, pend_g;
  logic rot_rise, dn_rise, rot_lvl_unused, dn_lvl_unused;
  logic issue, go_rot, go_h, go_dn, go_g, g_wrap, h_exp;
  logic [GW-1:0] g_cnt, g_per;
  logic [HW-1:0] h_cnt;
  logic [7:0] lines;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_rot (
    .clk(clk), .reset_n(reset_n), .raw(btn_rotate), .level(rot_lvl_unused), .rise(rot_rise)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dn (
    .clk(clk), .reset_n(reset_n), .raw(btn_down), .level(dn_lvl_unused), .rise(dn_rise)
  );

  // joystick band with hysteresis; leaving a side always drops to NONE before re-entering
  always_comb begin
    dir_hold = ((dir == RIGHT && adc_value <= 12'(TH_RIGHT - HYST)) ||
                (dir == LEFT && adc_value >= 12'(TH_LEFT + HYST))) ? NONE : dir;
    dir_nx = dir_hold != NONE ? dir_hold :
             adc_value > 12'(TH_RIGHT) ? RIGHT :
             adc_value < 12'(TH_LEFT) ? LEFT : NONE;
  end

  assign h_exp  = dir != NONE && dir_nx == dir && h_cnt == '0;
  assign g_wrap = g_cnt >= g_per - 1'b1;
  assign win    = pend_rot ? CMD_ROT : pend_h ? CMD_H : pend_dn ? CMD_DN : CMD_G;
  assign go_rot = issue && win == CMD_ROT;
  assign go_h   = issue && win == CMD_H;
  assign go_dn  = issue && win == CMD_DN;
  assign go_g   = issue && win == CMD_G;
  assign grid.level = lines >= 8'(LINES_PER_LEVEL * LEVEL_MAX) ? 4'(LEVEL_MAX)
                                                               : 4'(lines / 8'(LINES_PER_LEVEL));

`ifdef LEVEL_SPEEDUP_EN
  localparam int GSTEP = GRAVITY_CYC / 20;
  int g_per_lvl;
  assign g_per_lvl = GRAVITY_CYC - int'(grid.level) * GSTEP;
  // the shortened period is picked up only at a wrap so a running interval is never cut
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) g_per <= GW'(GRAVITY_CYC);
    else if (g_wrap) g_per <= GW'(g_per_lvl < GSTEP ? GSTEP : g_per_lvl);
`else
  assign g_per = GW'(GRAVITY_CYC);
`endif

  // scheduler next state: one command in flight, game over is terminal
  always_comb begin
    state_nx = state;
    issue = 1'b0;
    case (state)
      IDLE:
        if (grid.game_over) state_nx = OVER;
        else if (grid.grid_ready && (pend_rot || pend_h || pend_dn || pend_g)) begin
          state_nx = ISSUE;
          issue = 1'b1;
        end
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = grid.grid_ready ? IDLE : WAIT;
      default: state_nx = OVER;
    endcase
  end

  // scheduler state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;

  // command pulses and busy are registered from the issue decision
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      grid.rotate     <= 1'b0;
      grid.move_left  <= 1'b0;
      grid.move_right <= 1'b0;
      grid.move_down  <= 1'b0;
      grid.busy       <= 1'b0;
    end else begin
      grid.rotate     <= go_rot;
      grid.move_left  <= go_h && dir == LEFT;
      grid.move_right <= go_h && dir == RIGHT;
      grid.move_down  <= go_dn || go_g;
      grid.busy       <= state_nx == WAIT;
    end

  // pending requests: a fresh trigger beats the clear from its own issue, soft drop absorbs gravity
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pend_rot <= 1'b0;
      pend_h   <= 1'b0;
      pend_dn  <= 1'b0;
      pend_g   <= 1'b0;
    end else if (state == OVER) begin
      pend_rot <= 1'b0;
      pend_h   <= 1'b0;
      pend_dn  <= 1'b0;
      pend_g   <= 1'b0;
    end else begin
      pend_rot <= rot_rise || (pend_rot && !go_rot);
      pend_h   <= dir_nx != NONE && (dir_nx != dir || h_exp || (pend_h && !go_h));
      pend_dn  <= dn_rise || (pend_dn && !go_dn);
      pend_g   <= !go_dn && (g_wrap || (pend_g && !go_g));
    end

  // joystick direction and DAS/ARR repeat counter
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      dir   <= NONE;
      h_cnt <= '0;
    end else begin
      dir   <= dir_nx;
      h_cnt <= dir_nx == NONE ? '0 :
               dir_nx != dir ? HW'(DAS_CYC - 1) :
               h_exp ? HW'(ARR_CYC - 1) : h_cnt - 1'b1;
    end

  // free-running gravity counter, restarted by a soft drop
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) g_cnt <= '0;
    else g_cnt <= (go_dn || g_wrap) ? '0 : g_cnt + 1'b1;

  // cleared-line counter saturates so the level never wraps back down
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) lines <= '0;
    else if (grid.row_cleared && state != OVER && lines != 8'hFF) lines <= lines + 1'b1;
endmodule
